// File: rtl/lockin_pkg.sv
// Shared types and constants for the lock-in sweep path.
// Sweep FSM states, point-width and default sequencer timing.
package lockin_pkg;

    localparam int PTOS_W             = 16;
    localparam int RST_CYCLES_DEF     = 4;
    localparam int SETTLE_TIMEOUT_DEF = 4096;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST,
        ST_SETTLE,
        ST_RUN,
        ST_NEXT
    } sweep_state_t;

endpackage

// File: rtl/dac_sweep_sequencer_if.sv
// Control bundle between the sweep sequencer and the DAC driver.
// The sequencer is the master; the driver only returns its qualified sample strobe.
interface dac_sweep_sequencer_if;
    import lockin_pkg::*;

    logic              dac_reset_n;
    logic              dac_enable;
    logic [PTOS_W-1:0] ptos_x_ciclo;
    logic              seleccion_dac;
    logic              lu_table_input;
    logic              data_valid_dac_export;

    modport master (
        output dac_reset_n,
        output dac_enable,
        output ptos_x_ciclo,
        output seleccion_dac,
        output lu_table_input,
        input  data_valid_dac_export
    );

    modport slave (
        input  dac_reset_n,
        input  dac_enable,
        input  ptos_x_ciclo,
        input  seleccion_dac,
        input  lu_table_input,
        output data_valid_dac_export
    );

endinterface

// File: rtl/sample_period_counter.sv
// Counts valid samples modulo the points-per-cycle value and tracks waveform periods.
// wrap_o flags the sample that closes a period; last_period_o marks the final period of a point.
module sample_period_counter
    import lockin_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              inc_i,
    input  logic [PTOS_W-1:0] ptos_i,
    input  logic [PTOS_W-1:0] ciclos_i,
    output logic              wrap_o,
    output logic              last_period_o
);

    logic [PTOS_W-1:0] samp_q, samp_d;
    logic [PTOS_W-1:0] per_q, per_d;
    logic [PTOS_W-1:0] ciclos_eff;

    // A programmed period count of zero behaves as a single period.
    assign ciclos_eff    = (ciclos_i == '0) ? PTOS_W'(1) : ciclos_i;
    assign wrap_o        = inc_i && (samp_q == ptos_i - PTOS_W'(1));
    assign last_period_o = (per_q == ciclos_eff - PTOS_W'(1));

    always_comb begin
        samp_d = samp_q;
        per_d  = per_q;
        if (clr_i) begin
            samp_d = '0;
            per_d  = '0;
        end else if (inc_i) begin
            if (wrap_o) begin
                samp_d = '0;
                per_d  = per_q + PTOS_W'(1);
            end else begin
                samp_d = samp_q + PTOS_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            samp_q <= '0;
            per_q  <= '0;
        end else begin
            samp_q <= samp_d;
            per_q  <= per_d;
        end
    end

endmodule

// File: rtl/dac_sweep_sequencer.sv
// Steps the DAC driver through a points-per-cycle sweep, framing each point for lock-in logic.
// Every point: reset driver, wait for first valid sample, count full periods, advance.
module dac_sweep_sequencer
    import lockin_pkg::*;
#(
    parameter int RST_CYCLES     = RST_CYCLES_DEF,
    parameter int SETTLE_TIMEOUT = SETTLE_TIMEOUT_DEF
) (
    input  logic                  CLK_65,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [PTOS_W-1:0]     ptos_inicio,
    input  logic [PTOS_W-1:0]     ptos_fin,
    input  logic [PTOS_W-1:0]     ptos_paso,
    input  logic [PTOS_W-1:0]     ciclos_x_punto,
    dac_sweep_sequencer_if.master dac,
    output logic [PTOS_W-1:0]     punto_idx,
    output logic                  punto_start,
    output logic                  punto_done,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int RC_W = $clog2(RST_CYCLES + 1);
    localparam int TO_W = $clog2(SETTLE_TIMEOUT + 1);

    sweep_state_t      state_q, state_d;
    logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [PTOS_W-1:0] ptos_q, ptos_d;
    logic [PTOS_W-1:0] idx_q, idx_d;
    logic              pstart_q, pstart_d;
    logic              pdone_q, pdone_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              en_q, en_d;
    logic              drst_n_q, drst_n_d;

    logic [PTOS_W-1:0] fin_q, paso_q, ciclos_q;
    logic              latch_cfg;
    logic [PTOS_W:0]   sum;
    logic              cnt_clr, cnt_inc, wrap, last_period, pt_last;

    assign sum     = {1'b0, ptos_q} + {1'b0, paso_q};
    assign cnt_clr = (state_q != ST_SETTLE) && (state_q != ST_RUN);
    assign cnt_inc = dac.data_valid_dac_export && !cnt_clr;
    assign pt_last = wrap && last_period;

    sample_period_counter u_cnt (
        .clk_i         (CLK_65),
        .rst_ni        (reset_n),
        .clr_i         (cnt_clr),
        .inc_i         (cnt_inc),
        .ptos_i        (ptos_q),
        .ciclos_i      (ciclos_q),
        .wrap_o        (wrap),
        .last_period_o (last_period)
    );

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        to_cnt_d  = to_cnt_q;
        ptos_d    = ptos_q;
        idx_d     = idx_q;
        pstart_d  = 1'b0;
        pdone_d   = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        latch_cfg = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if ((ptos_inicio == '0) || (ptos_inicio > ptos_fin)) begin
                        err_d = 1'b1;
                    end else begin
                        latch_cfg = 1'b1;
                        ptos_d    = ptos_inicio;
                        idx_d     = '0;
                        rst_cnt_d = '0;
                        state_d   = ST_RST;
                    end
                end
            end
            ST_RST: begin
                if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) begin
                    to_cnt_d = '0;
                    state_d  = ST_SETTLE;
                end else begin
                    rst_cnt_d = rst_cnt_q + RC_W'(1);
                end
            end
            ST_SETTLE: begin
                // The first valid sample already counts toward the point total.
                if (dac.data_valid_dac_export) begin
                    pstart_d = 1'b1;
                    if (pt_last) begin
                        pdone_d = 1'b1;
                        state_d = ST_NEXT;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (to_cnt_q == TO_W'(SETTLE_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_RUN: begin
                if (pt_last) begin
                    pdone_d = 1'b1;
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                // sum[16] set implies sum > fin, so one 17-bit compare covers overflow.
                if ((paso_q == '0) || (sum > {1'b0, fin_q})) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    ptos_d    = sum[PTOS_W-1:0];
                    idx_d     = idx_q + PTOS_W'(1);
                    rst_cnt_d = '0;
                    state_d   = ST_RST;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_q != ST_IDLE) && abort) begin
            state_d  = ST_IDLE;
            ptos_d   = ptos_q;
            idx_d    = idx_q;
            pstart_d = 1'b0;
            pdone_d  = 1'b0;
            done_d   = 1'b0;
            err_d    = 1'b1;
        end

        busy_d   = (state_d != ST_IDLE);
        en_d     = (state_d == ST_SETTLE) || (state_d == ST_RUN) || (state_d == ST_NEXT);
        drst_n_d = en_d;
    end

    always_ff @(posedge CLK_65 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            rst_cnt_q <= '0;
            to_cnt_q  <= '0;
            ptos_q    <= '0;
            idx_q     <= '0;
            pstart_q  <= 1'b0;
            pdone_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            en_q      <= 1'b0;
            drst_n_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            to_cnt_q  <= to_cnt_d;
            ptos_q    <= ptos_d;
            idx_q     <= idx_d;
            pstart_q  <= pstart_d;
            pdone_q   <= pdone_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            en_q      <= en_d;
            drst_n_q  <= drst_n_d;
        end
    end

    always_ff @(posedge CLK_65) begin
        if (latch_cfg) begin
            fin_q    <= ptos_fin;
            paso_q   <= ptos_paso;
            ciclos_q <= ciclos_x_punto;
        end
    end

    assign dac.dac_reset_n    = drst_n_q;
    assign dac.dac_enable     = en_q;
    assign dac.ptos_x_ciclo   = ptos_q;
    assign dac.seleccion_dac  = 1'b0;
    assign dac.lu_table_input = busy_q;

    assign punto_idx   = idx_q;
    assign punto_start = pstart_q;
    assign punto_done  = pdone_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = err_q;

endmodule
